// File: rtl/sha256_block_seq.sv
// Block sequencer for the asic2 SHA-256 round core: buffers a 512-bit block, drives the core, accumulates the digest.
// Optional feature macro SHA_CHAIN_EN: start with chain=1 keeps H from the previous block.
module sha256_block_seq #(
  parameter int CORE_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        chain,
  input  logic        msg_valid,
  input  logic [31:0] msg_word,
  output logic        msg_ready,
  output logic        core_rst,
  output logic [31:0] core_var,
  output logic [31:0] core_w,
  input  logic [31:0] core_out,
  output logic        busy,
  output logic        dig_valid,
  output logic [2:0]  dig_idx,
  output logic [31:0] dig_word,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_CLR, S_LOAD, S_ROUND, S_WAIT, S_READ, S_DONE
  } state_t;

  localparam logic [5:0] WAIT_LAST = 6'(CORE_LAT - 1);

  state_t      state_r, state_s;
  logic [5:0]  cnt_r, cnt_s;
  logic [31:0] h_r [8];
  logic [31:0] w_r [16];
  logic [31:0] w_new_s;
  logic [31:0] sum_s;
  logic        accept_s;
  logic        h_init_s;

  function automatic logic [31:0] iv_word(input logic [2:0] idx);
    case (idx)
      3'd0:    iv_word = 32'h6a09e667;
      3'd1:    iv_word = 32'hbb67ae85;
      3'd2:    iv_word = 32'h3c6ef372;
      3'd3:    iv_word = 32'ha54ff53a;
      3'd4:    iv_word = 32'h510e527f;
      3'd5:    iv_word = 32'h9b05688c;
      3'd6:    iv_word = 32'h1f83d9ab;
      3'd7:    iv_word = 32'h5be0cd19;
      default: iv_word = 32'h00000000;
    endcase
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  assign accept_s = (state_r == S_FILL) & msg_valid;
  assign w_new_s  = sig1(w_r[14]) + w_r[9] + sig0(w_r[1]) + w_r[0];
  assign sum_s    = h_r[cnt_s[2:0]] + core_out;

`ifdef SHA_CHAIN_EN
  assign h_init_s = (state_r == S_IDLE) & start & ~chain;
`else
  logic unused_chain_s;
  assign unused_chain_s = chain;
  assign h_init_s = (state_r == S_IDLE) & start;
`endif

  // Next-state and phase counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_FILL;
          cnt_s   = 6'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FILL: begin
        if (accept_s && (cnt_r == 6'd15)) begin
          state_s = S_CLR;
          cnt_s   = 6'd0;
        end else if (accept_s) begin
          cnt_s = cnt_r + 6'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_CLR: begin
        state_s = S_LOAD;
        cnt_s   = 6'd0;
      end
      S_LOAD: begin
        if (cnt_r == 6'd7) begin
          state_s = S_ROUND;
          cnt_s   = 6'd0;
        end else begin
          cnt_s = cnt_r + 6'd1;
        end
      end
      S_ROUND: begin
        if (cnt_r == 6'd63) begin
          state_s = S_WAIT;
          cnt_s   = 6'd0;
        end else begin
          cnt_s = cnt_r + 6'd1;
        end
      end
      S_WAIT: begin
        if (cnt_r == WAIT_LAST) begin
          state_s = S_READ;
          cnt_s   = 6'd0;
        end else begin
          cnt_s = cnt_r + 6'd1;
        end
      end
      S_READ: begin
        if (cnt_r == 6'd7) begin
          state_s = S_DONE;
          cnt_s   = 6'd0;
        end else begin
          cnt_s = cnt_r + 6'd1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        cnt_s   = 6'd0;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = 6'd0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 6'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Schedule register: fills from the stream, then shifts one word per round
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) w_r[i] <= 32'h0;
    end else if (accept_s) begin
      for (int i = 0; i < 15; i++) w_r[i] <= w_r[i+1];
      w_r[15] <= msg_word;
    end else if (state_s == S_ROUND) begin
      for (int i = 0; i < 15; i++) w_r[i] <= w_r[i+1];
      w_r[15] <= w_new_s;
    end
  end

  // Running hash: IV on a fresh block, accumulate core results while reading
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) h_r[i] <= iv_word(3'(i));
    end else if (h_init_s) begin
      for (int i = 0; i < 8; i++) h_r[i] <= iv_word(3'(i));
    end else if (state_s == S_READ) begin
      h_r[cnt_s[2:0]] <= sum_s;
    end
  end

  // Registered outputs, computed from the state being entered; core_out word i is
  // presented the cycle before READ slot i so dig_word can be registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_ready <= 1'b0;
      core_rst  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dig_valid <= 1'b0;
      core_var  <= 32'h0;
      core_w    <= 32'h0;
      dig_word  <= 32'h0;
      dig_idx   <= 3'd0;
    end else begin
      msg_ready <= (state_s == S_FILL);
      core_rst  <= (state_s == S_CLR);
      busy      <= (state_s != S_IDLE);
      done      <= (state_s == S_DONE);
      dig_valid <= (state_s == S_READ);
      core_var  <= (state_s == S_LOAD) ? h_r[cnt_s[2:0]] : 32'h0;
      core_w    <= (state_s == S_ROUND) ? w_r[0] : 32'h0;
      dig_word  <= (state_s == S_READ) ? sum_s : 32'h0;
      dig_idx   <= (state_s == S_READ) ? cnt_s[2:0] : 3'd0;
    end
  end

endmodule

// File: tb/tb_sha256_block_seq.sv
// Self-checking bench for sha256_block_seq with a behavioural asic2 round-core model.
module tb_sha256_block_seq;
  localparam int CL = 2;
`ifdef SHA_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  localparam logic [7:0][31:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                     32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [7:0][31:0] ABC_DIG = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                          32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam logic [7:0][31:0] TWO_DIG = {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
                                          32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};
  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        chain = 1'b0;
  logic        msg_valid = 1'b0;
  logic [31:0] msg_word = 32'h0;
  logic        msg_ready, core_rst, busy, dig_valid, done;
  logic [31:0] core_var, core_w, dig_word;
  logic [31:0] core_out = 32'h0;
  logic [2:0]  dig_idx;

  sha256_block_seq #(.CORE_LAT(CL)) dut (
    .clk(clk), .reset(reset), .start(start), .chain(chain),
    .msg_valid(msg_valid), .msg_word(msg_word), .msg_ready(msg_ready),
    .core_rst(core_rst), .core_var(core_var), .core_w(core_w), .core_out(core_out),
    .busy(busy), .dig_valid(dig_valid), .dig_idx(dig_idx), .dig_word(dig_word), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One SHA-256 round on working variables v[0]=a .. v[7]=h
  function automatic logic [7:0][31:0] round_step(input logic [7:0][31:0] v, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] t1, t2;
    logic [7:0][31:0] r;
    t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w;
    t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    r[7] = v[6]; r[6] = v[5]; r[5] = v[4]; r[4] = v[3] + t1;
    r[3] = v[2]; r[2] = v[1]; r[1] = v[0]; r[0] = t1 + t2;
    return r;
  endfunction

  function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] hin, input logic [15:0][31:0] blk);
    logic [31:0] w [64];
    logic [7:0][31:0] v, r;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++) w[i] = ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16];
    v = hin;
    for (int i = 0; i < 64; i++) v = round_step(v, K_TAB[i], w[i]);
    for (int i = 0; i < 8; i++) r[i] = hin[i] + v[i];
    return r;
  endfunction

  // asic2 model: cleared by core_rst, loads 8 vars, runs 64 rounds, presents A..H after the latency
  int cm_idx = 1000;
  logic [7:0][31:0] cm_v = '0;
  always @(negedge clk) begin
    if (reset) cm_idx = 1000;
    else if (core_rst) cm_idx = 0;
    else if (cm_idx < 1000) cm_idx++;
    if (cm_idx >= 1 && cm_idx <= 8) cm_v[cm_idx-1] = core_var;
    else if (cm_idx >= 9 && cm_idx <= 72) cm_v = round_step(cm_v, K_TAB[cm_idx-9], core_w);
    if (cm_idx >= 72 + CL && cm_idx < 80 + CL) core_out = cm_v[cm_idx-72-CL];
    else core_out = 32'h0;
  end

  task automatic start_and_feed(input logic c, input logic rnd, input logic [15:0][31:0] blk, input int nwords);
    int n = 0;
    int cyc = 0;
    logic v;
    @(negedge clk);
    start = 1'b1; chain = c;
    @(negedge clk);
    start = 1'b0; chain = 1'b0;
    check("msg_ready_after_start", 32'(msg_ready), 32'd1);
    while (n < nwords && cyc < 400) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      msg_valid = v;
      msg_word  = v ? blk[n] : $urandom;
      if (v && msg_ready) n++;
      if (n < nwords) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("feed_count", 32'(n), 32'(nwords));
  endtask

  task automatic run_block(input int vi, input logic c, input logic rnd, input logic [15:0][31:0] blk,
                           input logic [7:0][31:0] hin, input logic [7:0][31:0] exp_dig);
    int rst_cnt = 0, rst_k = 0, n_dig = 0, first_dig_k = 0, done_k = 0, ready_seen = 0;
    logic [31:0] w16, w17;
    w16 = ssig1(blk[14]) + blk[9] + ssig0(blk[1]) + blk[0];
    w17 = ssig1(blk[15]) + blk[10] + ssig0(blk[2]) + blk[1];
    start_and_feed(c, rnd, blk, 16);
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (core_rst) begin rst_cnt++; rst_k = k; end
      if (msg_ready) ready_seen++;
      if (k >= 2 && k <= 9) check($sformatf("v%0d_core_var%0d", vi, k - 2), core_var, hin[k-2]);
      if (k == 26) check($sformatf("v%0d_core_w_t16", vi), core_w, w16);
      if (k == 27) check($sformatf("v%0d_core_w_t17", vi), core_w, w17);
      if (dig_valid) begin
        if (n_dig == 0) first_dig_k = k;
        if (n_dig < 8) begin
          check($sformatf("v%0d_dig_idx%0d", vi, n_dig), 32'(dig_idx), 32'(n_dig));
          check($sformatf("v%0d_dig_word%0d", vi, n_dig), dig_word, exp_dig[n_dig]);
        end
        n_dig++;
      end
      if (done) begin
        done_k = k;
        start = 1'b0; msg_valid = 1'b0;
        break;
      end
      start     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      msg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      msg_word  = $urandom;
    end
    check($sformatf("v%0d_core_rst_count", vi), 32'(rst_cnt), 32'd1);
    check($sformatf("v%0d_core_rst_cycle", vi), 32'(rst_k), 32'd1);
    check($sformatf("v%0d_ready_while_busy", vi), 32'(ready_seen), 32'd0);
    check($sformatf("v%0d_dig_count", vi), 32'(n_dig), 32'd8);
    check($sformatf("v%0d_first_dig_cycle", vi), 32'(first_dig_k), 32'(74 + CL));
    check($sformatf("v%0d_done_cycle", vi), 32'(done_k), 32'(82 + CL));
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", vi), 32'(done), 32'd0);
    check($sformatf("v%0d_busy_after", vi), 32'(busy), 32'd0);
  endtask

  task automatic reset_now(input string tag);
    @(negedge clk);
    msg_valid = 1'b0;
    reset = 1'b1;
    #1;
    check({tag, "_busy_in_reset"}, 32'(busy), 32'd0);
    check({tag, "_core_rst_in_reset"}, 32'(core_rst), 32'd0);
    check({tag, "_msg_ready_in_reset"}, 32'(msg_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_msg_ready_after"}, 32'(msg_ready), 32'd0);
  endtask

  typedef struct {
    logic             chain;
    logic             rnd;
    logic [15:0][31:0] blk;
    logic [7:0][31:0]  dig;
  } vec_t;

  vec_t vecs [5];
  logic [7:0][31:0] hin_tab [5];
  logic [15:0][31:0] abc_blk, b1_blk, b2_blk, rnd_blk;
  logic [7:0][31:0] prev;

  initial begin
    abc_blk = '0; abc_blk[0] = 32'h61626380; abc_blk[15] = 32'h00000018;
    b1_blk = '0;
    for (int i = 0; i < 14; i++) b1_blk[i] = {8'h61 + 8'(i), 8'h62 + 8'(i), 8'h63 + 8'(i), 8'h64 + 8'(i)};
    b1_blk[14] = 32'h80000000;
    b2_blk = '0; b2_blk[15] = 32'h000001c0;
    for (int i = 0; i < 16; i++) rnd_blk[i] = $urandom;

    vecs[0] = '{chain: 1'b0, rnd: 1'b0, blk: abc_blk, dig: ABC_DIG};
    vecs[1] = '{chain: 1'b0, rnd: 1'b0, blk: b1_blk,  dig: '0};
    vecs[2] = '{chain: 1'b1, rnd: 1'b0, blk: b2_blk,  dig: '0};
    vecs[3] = '{chain: 1'b0, rnd: 1'b1, blk: b2_blk,  dig: '0};
    vecs[4] = '{chain: 1'b1, rnd: 1'b1, blk: rnd_blk, dig: '0};
    prev = IV;
    for (int i = 0; i < 5; i++) begin
      hin_tab[i] = (CHAIN_EN && vecs[i].chain) ? prev : IV;
      if (i == 2 && CHAIN_EN) vecs[i].dig = TWO_DIG;
      else if (i != 0) vecs[i].dig = compress(hin_tab[i], vecs[i].blk);
      prev = vecs[i].dig;
    end

    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_msg_ready", 32'(msg_ready), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd0);
    check("rst_dig_valid", 32'(dig_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_core_var", core_var, 32'h0);
    check("rst_core_w", core_w, 32'h0);
    check("rst_dig_word", dig_word, 32'h0);
    check("rst_dig_idx", 32'(dig_idx), 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("start_during_reset_ignored", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) run_block(i, vecs[i].chain, vecs[i].rnd, vecs[i].blk, hin_tab[i], vecs[i].dig);

    start_and_feed(1'b0, 1'b0, b1_blk, 5);
    reset_now("partial_fill");
    run_block(10, 1'b1, 1'b0, abc_blk, IV, ABC_DIG);

    start_and_feed(1'b0, 1'b0, rnd_blk, 16);
    @(negedge clk);
    msg_valid = 1'b0;
    repeat (30) @(negedge clk);
    reset_now("mid_round");
    run_block(11, 1'b1, 1'b0, abc_blk, IV, ABC_DIG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sha256_block_seq.md
# sha256_block_seq

Block sequencer for the asic2 SHA-256 round core. It buffers one 512-bit message block from a 32-bit valid/ready stream, clears and loads the core with the eight working variables, and expands the message schedule on the fly to feed one W word per round for 64 rounds. It then reads back the eight result words, adds them to the running hash, and streams out the digest. It sits between the message source (padding/UART front end) and asic2, and owns the core's `reset`, `in_var` and `in_w` pins.

## Interface
Parameters:
- `CORE_LAT`, 2: cycles from the last round word to the first valid `core_out` word (A first).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse; begins a block when IDLE.
- `chain`  in  1  sampled with `start`; 1 = continue from the previous digest (see Configuration).
- `msg_valid`  in  1  message word valid.
- `msg_word`  in  32  message word, W0 first, big-endian per word.
- `msg_ready`  out  1  high only in FILL.
- `core_rst`  out  1  drives asic2 `reset`; high for exactly one cycle in CLR.
- `core_var`  out  32  drives asic2 `in_var`.
- `core_w`  out  32  drives asic2 `in_w`.
- `core_out`  in  32  asic2 `out_var`.
- `busy`  out  1  high in every state except IDLE.
- `dig_valid`  out  1  digest word valid.
- `dig_idx`  out  3  digest word index, 0 = H0.
- `dig_word`  out  32  digest word.
- `done`  out  1  one-cycle pulse after the eighth digest word.

## Operation
- States: IDLE → FILL → CLR → LOAD → ROUND → WAIT → READ → DONE → IDLE.
- IDLE:
  - `start`=1 → FILL.
  - H registers are set to the IV (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19) unless chaining applies.
- FILL:
  - `msg_ready`=1.
  - Each `msg_valid & msg_ready` cycle shifts `msg_word` into the 16-entry schedule register `w[0..15]`; the first word ends in `w[0]`.
  - After the 16th accepted word → CLR; `msg_ready` drops in the same cycle as the transition.
  - No timeout.
- CLR: one cycle, `core_rst`=1 → LOAD.
- LOAD:
  - 8 cycles, index i = 0..7, `core_var` = H[i] (A..H order).
  - Then → ROUND.
- ROUND:
  - 64 cycles, t = 0..63, `core_w` = `w[0]`.
  - Each cycle the register shifts down by one, and `w[15]` ← σ1(w[14]) + w[9] + σ0(w[1]) + w[0].
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - All additions are mod 2^32.
  - Then → WAIT.
- WAIT: `CORE_LAT` cycles → READ.
- READ:
  - 8 cycles, i = 0..7.
  - H[i] ← H[i] + `core_out` (mod 2^32).
  - `dig_word` = the new H[i], `dig_idx` = i, `dig_valid`=1.
- DONE: `done`=1 for one cycle → IDLE. H is retained.
- Outside LOAD, `core_var` = 0. Outside ROUND, `core_w` = 0.
- `start` while busy is ignored. `msg_valid` outside FILL is ignored, and no word is consumed.
- No backpressure on the digest output: the consumer must accept 8 consecutive words.

## Timing
- Reset values:
  - State = IDLE.
  - `msg_ready`, `core_rst`, `busy`, `dig_valid`, `done` = 0.
  - `core_var`, `core_w`, `dig_word` = 0; `dig_idx` = 0.
  - H = IV; `w` = 0.
- All outputs are registered. `core_rst` is the only output intended to feed an asynchronous pin, and it is glitch-free because it is registered.
- From `start` to the first `msg_ready`: 1 cycle.
- From the 16th accepted word to the first digest word: 1 (CLR) + 8 + 64 + `CORE_LAT` cycles.
- Total after FILL: 1 + 8 + 64 + `CORE_LAT` + 8 + 1 = 84 cycles at `CORE_LAT`=2.
- Reset mid-operation (any state) returns to IDLE within the asynchronous assertion. A partial FILL is discarded and H returns to the IV.
- `start` and `reset` high together: reset wins.

## Configuration
- `SHA_CHAIN_EN` defined:
  - `start` with `chain`=1 keeps H from the previous block, for multi-block messages.
  - `chain`=0 reloads the IV.
- `SHA_CHAIN_EN` not defined:
  - `chain` is ignored and every block starts from the IV.
  - The H-hold mux is removed.
  - Digests are single-block only.

## Test plan
- Reset mid-ROUND, then release → `busy`=0, `core_rst`=0, `msg_ready`=0. A subsequent `start` with "abc" yields the correct digest.
- `start` followed by 16 words for "abc" (W0=61626380, W1..W14=0, W15=00000018) → the cycle-1 and cycle-2 ROUND `core_w` values follow schedule order. Checked values: `core_w` at t=16 = 61626380 and at t=17 = 000f0000. Digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. `done` arrives 84 cycles after the last word.
- LOAD check → `core_var` equals the IV words in order, one per cycle. `core_rst` is high exactly one cycle, immediately before LOAD.
- `msg_valid` toggled randomly during FILL → only handshaken words are consumed. `start` and `msg_valid` pulses while busy have no effect.
- With `SHA_CHAIN_EN`: the 2-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" message, second block sent with `chain`=1 → digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Without the macro: the same 2-block sequence with `chain`=1 → the second block's digest equals its standalone IV-based hash.
